// File: rtl/mempool_wakeup_dispatch.sv
// Retimes the wake-up pulse mask per group, holds a sticky pending bit per core and
// delivers one registered pulse per core while it sits in WFI. Optional drop counter: MEMPOOL_WAKEUP_STATS_EN.
module mempool_wakeup_dispatch #(
  parameter int NumCores      = 256,
  parameter int NumGroups     = 4,
  parameter int NumPipeStages = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumCores-1:0] wake_up_i,
  input  logic [NumCores-1:0] core_wfi_i,
  output logic [NumCores-1:0] wake_up_o,
  output logic [NumCores-1:0] pending_o,
  output logic                busy_o,
  output logic [31:0]         dropped_o
);

  localparam int GroupWidth = NumCores / NumGroups;

  logic [NumCores-1:0]  arr;
  logic [NumCores-1:0]  issue;
  logic [NumCores-1:0]  pending_q;
  logic [NumCores-1:0]  wake_up_q;
  logic [NumGroups-1:0] group_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NumGroups; gi++) begin : g_group
      if (NumPipeStages == 0) begin : g_bypass
        assign arr[gi*GroupWidth +: GroupWidth] = wake_up_i[gi*GroupWidth +: GroupWidth];
        assign group_busy[gi] = 1'b0;
      end else begin : g_pipe
        logic [GroupWidth-1:0] stage_q [NumPipeStages];
        logic                  stage_any;

        always_ff @(posedge clk_i) begin
          if (!rst_ni) begin
            for (int s = 0; s < NumPipeStages; s++) stage_q[s] <= '0;
          end else begin
            stage_q[0] <= wake_up_i[gi*GroupWidth +: GroupWidth];
            for (int s = 1; s < NumPipeStages; s++) stage_q[s] <= stage_q[s-1];
          end
        end

        always_comb begin
          stage_any = 1'b0;
          for (int s = 0; s < NumPipeStages; s++) stage_any = stage_any | (|stage_q[s]);
        end

        assign arr[gi*GroupWidth +: GroupWidth] = stage_q[NumPipeStages-1];
        assign group_busy[gi] = stage_any;
      end
    end
  endgenerate

  // The ~wake_up_q term keeps a core from being hit twice while its WFI flag is still dropping.
  assign issue = pending_q & core_wfi_i & ~wake_up_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      wake_up_q <= '0;
    end else begin
      pending_q <= (pending_q & ~issue) | arr;
      wake_up_q <= issue;
    end
  end

  assign wake_up_o = wake_up_q;
  assign pending_o = pending_q;
  assign busy_o    = (|pending_q) | (|group_busy);

`ifdef MEMPOOL_WAKEUP_STATS_EN
  localparam int CountWidth = $clog2(NumCores + 1);

  logic [NumCores-1:0]   drop;
  logic [CountWidth-1:0] drop_num;
  logic [32:0]           drop_sum;
  logic [31:0]           dropped_q;

  // A request landing on an already-pending core that is not being served this cycle is absorbed.
  assign drop = arr & pending_q & ~issue;

  always_comb begin
    drop_num = '0;
    for (int c = 0; c < NumCores; c++) drop_num = drop_num + CountWidth'(drop[c]);
  end

  assign drop_sum = {1'b0, dropped_q} + 33'(drop_num);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) dropped_q <= '0;
    else         dropped_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
  end

  assign dropped_o = dropped_q;
`else
  assign dropped_o = 32'h0;
`endif

endmodule
